clk_div_multi: RTL and testbench

- Multi-channel programmable clock divider. This block is the next generation of the team's fixed single-output divider.
- Each channel produces a 50%-duty divided clock. Its half-period is reprogrammable at runtime.
- New divisors are applied glitch-free at the channel's next half-period boundary.
- Sits between the system clock and the LED-flow, blink and scan logic, replacing per-use fixed dividers.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_ch.sv | 98 +++++++++
 rtl/clk_div_multi.sv | 65 ++++++
 tb/tb_clk_div_multi.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the multi-channel clock divider.
//   CNT_W_DEF        : default half-period counter / divisor width
//   DEF_HALF_1HZ_50M : reset half-period minus 1 giving 1 Hz from 50 MHz
//   half_t           : half-period value at the default width
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int          CNT_W_DEF        = 26;
  localparam int unsigned DEF_HALF_1HZ_50M = 24_999_999;

  typedef logic [CNT_W_DEF-1:0] half_t;

endpackage

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One divider channel: half-period counter, active and shadow divisors,
// pending flag and registered 50%-duty output.
// Optional macro CLK_DIV_TICK_EN adds a one-cycle 'tick' pulse on each
// rising edge of clk_out.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   en       in   channel run enable
//   we       in   divisor write strobe, already decoded for this channel
//   wdata    in   new half-period minus 1
//   restart  in   realign to phase 0
//   clk_out  out  divided clock (flop output)
//   pending  out  shadow divisor written but not yet applied
//   tick     out  (CLK_DIV_TICK_EN only) pulse with each 0->1 of clk_out
// -----------------------------------------------------------------------------
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_1HZ_50M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             restart,
  output logic             clk_out,
`ifdef CLK_DIV_TICK_EN
  output logic             tick,
`endif
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_act;
  logic [CNT_W-1:0] h_sh;
  logic             boundary;
  logic             apply;

  // Restart outranks a boundary toggle, so a boundary only counts while the
  // channel is running and not being realigned.
  assign boundary = en && !restart && (cnt == h_act);

  // The active divisor may only change where the counter restarts from 0,
  // which keeps every half period whole.
  assign apply = restart || !en || boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (restart || !en) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == h_act) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // A write in the same cycle as an apply: the apply takes the old shadow
  // (non-blocking read), the new value lands in the shadow and the later
  // pending<=1 wins, so it waits for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_act   <= DEF_HALF;
      h_sh    <= DEF_HALF;
      pending <= 1'b0;
    end else begin
      if (apply && pending) begin
        h_act   <= h_sh;
        pending <= 1'b0;
      end
      if (we) begin
        h_sh    <= wdata;
        pending <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_TICK_EN
  // Registered alongside clk_out so it is high exactly in the first cycle
  // clk_out reads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= boundary && !clk_out;
    end
  end
`endif

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable clock divider. Each channel emits a 50%-duty
// divided clock whose half period (H+1 cycles) can be rewritten at runtime;
// new divisors take effect glitch-free at the next half-period boundary.
// Optional macro CLK_DIV_TICK_EN adds the 'tick' output.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   ch_en        in   per-channel run enable
//   cfg_we       in   one-cycle divisor write strobe
//   cfg_ch       in   target channel (out-of-range writes are ignored)
//   cfg_half     in   new half-period minus 1
//   sync_restart in   realign all channels to phase 0
//   clk_out      out  divided clocks, registered
//   cfg_pending  out  per-channel shadow-not-yet-applied flag
//   tick         out  (CLK_DIV_TICK_EN only) rising-edge pulse per channel
// -----------------------------------------------------------------------------
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_HALF = DEF_HALF_1HZ_50M,
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clk_out,
`ifdef CLK_DIV_TICK_EN
  output logic [NUM_CH-1:0] tick,
`endif
  output logic [NUM_CH-1:0] cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;

    // An index beyond NUM_CH-1 matches no channel, so such writes vanish.
    assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (CNT_W'(DEF_HALF))
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[i]),
      .we       (we_ch),
      .wdata    (cfg_half),
      .restart  (sync_restart),
      .clk_out  (clk_out[i]),
`ifdef CLK_DIV_TICK_EN
      .tick     (tick[i]),
`endif
      .pending  (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi with NUM_CH=3, CNT_W=8, DEF_HALF=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Comments of the form "P<n>" name the rising edge counted from the last
// reset release / enable. With CLK_DIV_TICK_EN defined the tick output is
// checked as well.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              sync_restart;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] cfg_pending;
`ifdef CLK_DIV_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif

  int checks_total;
  int checks_passed;
  int checks_failed;

  clk_div_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_en        (ch_en),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_half     (cfg_half),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
`ifdef CLK_DIV_TICK_EN
    .tick         (tick),
`endif
    .cfg_pending  (cfg_pending)
  );

  // 10-unit clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      checks_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one cycle of config/restart inputs from a falling edge and returns
  // on the next falling edge with the strobes cleared.
  task automatic applyStimulus(input logic we, input logic [CH_W-1:0] ch,
                               input logic [CNT_W-1:0] half,
                               input logic restart);
    cfg_we       = we;
    cfg_ch       = ch;
    cfg_half     = half;
    sync_restart = restart;
    @(negedge clk);
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic checkTick(input string tag, input logic [NUM_CH-1:0] expected);
`ifdef CLK_DIV_TICK_EN
    checkOutput(tag, 8'(tick), 8'(expected));
`else
    if (expected === 'x) $display("[TB] unreachable");
`endif
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    checks_failed = 0;
    rst          = 1'b1;
    ch_en        = '0;
    cfg_we       = 1'b0;
    cfg_ch       = '0;
    cfg_half     = '0;
    sync_restart = 1'b0;

    waitCycles(2);
    checkOutput("reset_clk_out", 8'(clk_out), 8'h0);
    checkOutput("reset_pending", 8'(cfg_pending), 8'h0);

    // Default period: H=3, first rise 4 edges after enable, period 8.
    rst   = 1'b0;
    ch_en = 3'b111;
    waitCycles(3);                                     // P3
    checkOutput("def_p3", 8'(clk_out), 8'h0);
    waitCycles(1);                                     // P4
    checkOutput("def_p4_rise", 8'(clk_out), 8'h7);
    checkTick("def_p4_tick", 3'b111);
    waitCycles(1);                                     // P5
    checkTick("def_p5_tick", 3'b000);
    waitCycles(2);                                     // P7
    checkOutput("def_p7", 8'(clk_out), 8'h7);
    waitCycles(1);                                     // P8
    checkOutput("def_p8_fall", 8'(clk_out), 8'h0);

    // H=0 on channel 1: pending until the P12 boundary, then clk/2.
    applyStimulus(1'b1, 2'd1, 8'd0, 1'b0);             // P9
    checkOutput("h0_pend_p9", 8'(cfg_pending), 8'h2);
    waitCycles(2);                                     // P11
    checkOutput("h0_pend_p11", 8'(cfg_pending), 8'h2);
    waitCycles(1);                                     // P12
    checkOutput("h0_pend_p12", 8'(cfg_pending), 8'h0);
    checkOutput("h0_out_p12", 8'(clk_out), 8'h7);
    waitCycles(1);                                     // P13
    checkOutput("h0_out_p13", 8'(clk_out), 8'h5);
    waitCycles(1);                                     // P14
    checkOutput("h0_out_p14", 8'(clk_out), 8'h7);
    waitCycles(1);                                     // P15
    checkOutput("h0_out_p15", 8'(clk_out), 8'h5);
    waitCycles(1);                                     // P16
    checkOutput("h0_out_p16", 8'(clk_out), 8'h2);

    // Out-of-range channel index 3: no pending flag anywhere.
    applyStimulus(1'b1, 2'd3, 8'd9, 1'b0);             // P17
    checkOutput("oor_pending", 8'(cfg_pending), 8'h0);
    checkOutput("oor_clk_out", 8'(clk_out), 8'h0);

    // Realign, then overwrite ch0 shadow 5 -> 7 before its P22 boundary.
    applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);             // P18
    checkOutput("rs1_clk_out", 8'(clk_out), 8'h0);
    applyStimulus(1'b1, 2'd0, 8'd5, 1'b0);             // P19
    applyStimulus(1'b1, 2'd0, 8'd7, 1'b0);             // P20
    checkOutput("ow_pend_p20", 8'(cfg_pending), 8'h1);
    waitCycles(2);                                     // P22
    checkOutput("ow_pend_p22", 8'(cfg_pending), 8'h0);
    checkOutput("ow_rise_p22", 8'(clk_out[0]), 8'h1);
    waitCycles(7);                                     // P29
    checkOutput("ow_high_p29", 8'(clk_out[0]), 8'h1);
    waitCycles(1);                                     // P30
    checkOutput("ow_fall_p30", 8'(clk_out[0]), 8'h0);

    // Write H=9 to ch0 exactly on its P38 boundary: old H=7 runs once more.
    waitCycles(7);                                     // P37
    applyStimulus(1'b1, 2'd0, 8'd9, 1'b0);             // P38
    checkOutput("wab_rise_p38", 8'(clk_out[0]), 8'h1);
    checkOutput("wab_pend_p38", 8'(cfg_pending[0]), 8'h1);
    waitCycles(7);                                     // P45
    checkOutput("wab_high_p45", 8'(clk_out[0]), 8'h1);
    checkOutput("wab_pend_p45", 8'(cfg_pending[0]), 8'h1);
    waitCycles(1);                                     // P46
    checkOutput("wab_fall_p46", 8'(clk_out[0]), 8'h0);
    checkOutput("wab_pend_p46", 8'(cfg_pending[0]), 8'h0);
    waitCycles(9);                                     // P55
    checkOutput("wab_low_p55", 8'(clk_out[0]), 8'h0);
    waitCycles(1);                                     // P56
    checkOutput("wab_rise_p56", 8'(clk_out[0]), 8'h1);

    // Mixed phases: ch0 H=3, ch2 H=5 pending, restart with a ch1 write.
    applyStimulus(1'b1, 2'd0, 8'd3, 1'b0);             // P57
    applyStimulus(1'b1, 2'd2, 8'd5, 1'b0);             // P58
    applyStimulus(1'b1, 2'd1, 8'd0, 1'b1);             // P59
    checkOutput("rs2_clk_out", 8'(clk_out), 8'h0);
    checkOutput("rs2_pending", 8'(cfg_pending), 8'h2);
    waitCycles(1);                                     // P60
    checkOutput("rs2_pend_p60", 8'(cfg_pending), 8'h0);
    waitCycles(2);                                     // P62
    checkOutput("rs2_out_p62", 8'(clk_out), 8'h2);
    waitCycles(1);                                     // P63
    checkOutput("rs2_out_p63", 8'(clk_out), 8'h1);
    checkTick("rs2_tick_p63", 3'b001);
    waitCycles(1);                                     // P64
    checkOutput("rs2_out_p64", 8'(clk_out), 8'h3);
    checkTick("rs2_tick_p64", 3'b010);
    waitCycles(1);                                     // P65
    checkOutput("rs2_out_p65", 8'(clk_out), 8'h5);
    checkTick("rs2_tick_p65", 3'b100);

    // Disable ch2 mid-period with a pending H=1, then re-enable.
    applyStimulus(1'b1, 2'd2, 8'd1, 1'b0);             // P66
    checkOutput("dis_pend_p66", 8'(cfg_pending), 8'h4);
    ch_en = 3'b011;
    waitCycles(1);                                     // P67
    checkOutput("dis_out_p67", 8'(clk_out[2]), 8'h0);
    checkOutput("dis_pend_p67", 8'(cfg_pending[2]), 8'h0);
    ch_en = 3'b111;
    waitCycles(1);                                     // P68
    checkOutput("en_out_p68", 8'(clk_out[2]), 8'h0);
    waitCycles(1);                                     // P69
    checkOutput("en_rise_p69", 8'(clk_out[2]), 8'h1);
    checkTick("en_tick_p69", 3'b100);
    waitCycles(2);                                     // P71
    checkOutput("en_fall_p71", 8'(clk_out[2]), 8'h0);

    // Async reset mid-count with ch0 shadow pending; no clock edge needed.
    applyStimulus(1'b1, 2'd0, 8'd2, 1'b0);             // P72
    checkOutput("ar_pend_p72", 8'(cfg_pending), 8'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_clk_out", 8'(clk_out), 8'h0);
    checkOutput("ar_pending", 8'(cfg_pending), 8'h0);
    checkTick("ar_tick", 3'b000);

    // After release the default H=3 is back; the lost shadow (H=2) would
    // have produced a rise at P3.
    waitCycles(1);
    rst = 1'b0;
    waitCycles(1);                                     // P1
    checkOutput("ar2_pend_p1", 8'(cfg_pending), 8'h0);
    waitCycles(2);                                     // P3
    checkOutput("ar2_out_p3", 8'(clk_out), 8'h0);
    waitCycles(1);                                     // P4
    checkOutput("ar2_out_p4", 8'(clk_out), 8'h7);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
